// File: rtl/rx_dcoffset_trim_if.sv
// Sample and serial-control bundle for rx_dcoffset_trim.
// master drives samples and register writes; slave is the trim block.
interface rx_dcoffset_trim_if #(
  parameter int WIDTH = 16
);
  logic [6:0]              serial_addr;
  logic [31:0]             serial_data;
  logic                    serial_strobe;
  logic                    in_strobe;
  logic signed [WIDTH-1:0] in;
  logic                    out_strobe;
  logic signed [WIDTH-1:0] out;
  logic signed [WIDTH-1:0] offset_rb;

  modport master (
    output serial_addr, serial_data, serial_strobe, in_strobe, in,
    input  out_strobe, out, offset_rb
  );

  modport slave (
    input  serial_addr, serial_data, serial_strobe, in_strobe, in,
    output out_strobe, out, offset_rb
  );
endinterface

// File: rtl/rx_dcoffset_trim.sv
// RX DC offset trim: subtracts a running (or host-frozen) offset estimate
// from each strobed ADC sample and saturates the result to WIDTH bits.
// The estimate is the integer part of a first-order integrator whose
// fractional tail is ALPHA_SHIFT bits, giving a 2^ALPHA_SHIFT time constant.
module rx_dcoffset_trim #(
  parameter int         WIDTH       = 16,
  parameter int         ALPHA_SHIFT = 12,
  parameter logic [6:0] ADDR        = 7'd0
) (
  input logic              clock,
  input logic              reset,
  rx_dcoffset_trim_if.slave bus
);
  localparam int AW     = WIDTH + ALPHA_SHIFT;
  localparam int STAGES = 1;

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]    AMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0]    AMIN = {1'b1, {(AW-1){1'b0}}};

  // Decoded control-word write.
  typedef struct packed {
    logic                    wr;
    logic                    frz;
    logic signed [WIDTH-1:0] val;
  } cfg_wr_t;

  cfg_wr_t                 cw;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    acc_nxt;
  logic                    freeze;
  logic signed [WIDTH-1:0] offset;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] clip;
  logic signed [AW:0]      sum;
  logic signed [WIDTH-1:0] out_r;
  logic [STAGES:0]         vld_pipe;

  // Bits between WIDTH and the freeze flag carry no meaning here.
  logic unused_data;
  assign unused_data = ^bus.serial_data[30:WIDTH];

  // Decode a write aimed at this block's register address.
  always_comb begin
    cw.wr  = bus.serial_strobe && (bus.serial_addr == ADDR);
    cw.frz = bus.serial_data[31];
    cw.val = bus.serial_data[WIDTH-1:0];
  end

  // Integer part of the integrator is the live offset estimate.
  assign offset = acc[AW-1:ALPHA_SHIFT];

  // One extra bit keeps in - offset exact before clipping.
  assign diff = {bus.in[WIDTH-1], bus.in} - {offset[WIDTH-1], offset};

  // Saturate the corrected sample back into WIDTH bits.
  always_comb begin
    clip = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1])
      clip = diff[WIDTH] ? SMIN : SMAX;
  end

  // Integrator step on the clipped error; pinned at the rails, never wraps.
  assign sum = {acc[AW-1], acc} + {{(ALPHA_SHIFT+1){clip[WIDTH-1]}}, clip};

  always_comb begin
    acc_nxt = sum[AW-1:0];
    if (sum[AW] != sum[AW-1])
      acc_nxt = sum[AW] ? AMIN : AMAX;
  end

  // Host load beats tracking; the sample in the same cycle already used the old offset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      freeze <= 1'b0;
    end else if (cw.wr) begin
      acc    <= {cw.val, {ALPHA_SHIFT{1'b0}}};
      freeze <= cw.frz;
    end else if (bus.in_strobe && !freeze) begin
      acc    <= acc_nxt;
    end
  end

  // Valid travels alongside the single output register stage.
  assign vld_pipe[0] = bus.in_strobe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Output register captures only on a strobe and holds otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             out_r <= '0;
    else if (vld_pipe[0])  out_r <= clip;
  end

  assign bus.out        = out_r;
  assign bus.out_strobe = vld_pipe[STAGES];
  assign bus.offset_rb  = offset;
endmodule

// File: tb/tb_rx_dcoffset_trim.sv
// Bench for rx_dcoffset_trim: directed corner cases plus a randomized run,
// every cycle compared against an integer-arithmetic reference model.
module tb_rx_dcoffset_trim;
  localparam int         W    = 16;
  localparam int         AS   = 12;
  localparam logic [6:0] ADDR = 7'd0;
  localparam longint     SMAXL = (longint'(1) << (W-1)) - 1;
  localparam longint     SMINL = -(longint'(1) << (W-1));
  localparam longint     AMAXL = (longint'(1) << (W+AS-1)) - 1;
  localparam longint     AMINL = -(longint'(1) << (W+AS-1));

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rx_dcoffset_trim_if #(.WIDTH(W)) bus ();

  rx_dcoffset_trim #(.WIDTH(W), .ALPHA_SHIFT(AS), .ADDR(ADDR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: integrator as a plain integer scaled by 2^AS.
  longint m_acc  = 0;
  bit     m_frz  = 1'b0;
  longint m_out  = 0;
  bit     m_ostb = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clipw(input longint v);
    if (v > SMAXL) return SMAXL;
    if (v < SMINL) return SMINL;
    return v;
  endfunction

  function automatic longint m_offset();
    return m_acc >>> AS;  // floor(acc / 2^AS)
  endfunction

  task automatic model_step();
    longint c, s;
    c = clipw(longint'($signed(bus.in)) - m_offset());
    if (bus.serial_strobe && bus.serial_addr == ADDR) begin
      m_acc = longint'($signed(bus.serial_data[W-1:0])) * (longint'(1) << AS);
      m_frz = bus.serial_data[31];
    end else if (bus.in_strobe && !m_frz) begin
      s = m_acc + c;
      m_acc = (s > AMAXL) ? AMAXL : (s < AMINL) ? AMINL : s;
    end
    if (bus.in_strobe) m_out = c;
    m_ostb = bus.in_strobe;
  endtask

  task automatic drive(input bit stb, input longint v, input bit sw,
                       input logic [6:0] a, input logic [31:0] d);
    bus.in_strobe     = stb;
    bus.in            = W'(v);
    bus.serial_strobe = sw;
    bus.serial_addr   = a;
    bus.serial_data   = d;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("out", longint'(bus.out), m_out);
    chk("out_strobe", longint'(bus.out_strobe), longint'(m_ostb));
    chk("offset_rb", longint'(bus.offset_rb), m_offset());
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 7'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_acc = 0; m_frz = 0; m_out = 0; m_ostb = 0;
    chk("rst_out", longint'(bus.out), 0);
    chk("rst_ostb", longint'(bus.out_strobe), 0);
    chk("rst_rb", longint'(bus.offset_rb), 0);
  endtask

  initial begin
    longint prev, v;
    int     mono_bad;
    logic [31:0] d;

    // 1: single strobe from reset
    do_reset();
    drive(1, 100, 0, 7'd0, 32'd0); tick();
    chk("t1_out", longint'(bus.out), 100);
    chk("t1_ostb", longint'(bus.out_strobe), 1);
    chk("t1_rb", longint'(bus.offset_rb), 0);
    drive(0, 0, 0, 7'd0, 32'd0); tick();
    chk("t1_ostb_drop", longint'(bus.out_strobe), 0);
    chk("t1_out_hold", longint'(bus.out), 100);

    // 2: frozen host offset 100
    drive(0, 0, 1, ADDR, 32'h8000_0064); tick();
    chk("t2_rb_load", longint'(bus.offset_rb), 100);
    drive(1, 300, 0, 7'd0, 32'd0); tick();
    chk("t2_out", longint'(bus.out), 200);
    for (int i = 0; i < 1000; i++) begin
      drive(1, longint'($signed(16'($urandom))), 0, 7'd0, 32'd0); tick();
    end
    chk("t2_rb_frozen", longint'(bus.offset_rb), 100);

    // 3: clipping at both rails
    drive(0, 0, 1, ADDR, 32'h8000_8000); tick();
    chk("t3_rb_min", longint'(bus.offset_rb), -32768);
    drive(1, 32767, 0, 7'd0, 32'd0); tick();
    chk("t3_clip_hi", longint'(bus.out), 32767);
    drive(0, 0, 1, ADDR, 32'h8000_7FFF); tick();
    drive(1, -32768, 0, 7'd0, 32'd0); tick();
    chk("t3_clip_lo", longint'(bus.out), -32768);

    // 5: load collides with a strobe
    drive(0, 0, 1, ADDR, 32'h8000_0064); tick();
    drive(1, 500, 1, ADDR, 32'h8000_0032); tick();
    chk("t5_old_off", longint'(bus.out), 400);
    chk("t5_rb_new", longint'(bus.offset_rb), 50);
    drive(1, 500, 0, 7'd0, 32'd0); tick();
    chk("t5_new_off", longint'(bus.out), 450);

    // 6b: write to a neighbouring address must not touch acc or freeze
    drive(0, 0, 1, ADDR + 7'd1, 32'h0000_1234); tick();
    chk("t6_rb_other", longint'(bus.offset_rb), 50);
    drive(1, 500, 0, 7'd0, 32'd0); tick();
    chk("t6_out_other", longint'(bus.out), 450);
    chk("t6_still_frozen", longint'(bus.offset_rb), 50);

    // 6a: asynchronous reset mid-stream, unfrozen offset 512
    drive(0, 0, 1, ADDR, 32'h0000_0200); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1000, 0, 7'd0, 32'd0); tick();
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_out", longint'(bus.out), 0);
    chk("t6_async_ostb", longint'(bus.out_strobe), 0);
    chk("t6_async_rb", longint'(bus.offset_rb), 0);
    @(negedge clock);
    do_reset();

    // 4: convergence on a constant input
    drive(1, 1000, 0, 7'd0, 32'd0);
    prev = 32767; mono_bad = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (longint'(bus.out) > prev) mono_bad++;
      prev = longint'(bus.out);
    end
    chk("t4_rb_conv", longint'(bus.offset_rb == 999 || bus.offset_rb == 1000), 1);
    chk("t4_out_small", longint'(bus.out >= -1 && bus.out <= 1), 1);
    chk("t4_monotonic", longint'(mono_bad), 0);

    // Randomized traffic: samples, loads, stray addresses, freeze toggling
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0:       v = SMAXL;
        1:       v = SMINL;
        default: v = longint'($signed(16'($urandom)));
      endcase
      d = $urandom;
      d[31] = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, v, $urandom_range(0, 31) == 0,
            ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR, d);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
